// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson counter / decoder pair.
package johnson_pkg;

    typedef enum logic [0:0] {SEARCH, LOCKED} state_t;

    localparam int unsigned ERR_CNT_W = 8;
    // Widest code the helper function can produce.
    localparam int unsigned MAX_W = 32;

    // Canonical Johnson pattern for position idx in a width-bit sequence.
    // First half fills ones from the LSB up; second half clears them from the LSB up.
    function automatic logic [MAX_W-1:0] johnson_code(input int unsigned idx,
                                                      input int unsigned width);
        logic [MAX_W-1:0] code;
        code = '0;
        for (int unsigned b = 0; b < MAX_W; b++) begin
            if (b < width) begin
                code[b] = (idx < width) ? (b < idx) : (b + width >= idx);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/johnson_decode_comb.sv
// Pure combinational Johnson code -> index decode with legality check.
module johnson_decode_comb
    import johnson_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned IW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] code_in,
    output logic [IW-1:0]    index,
    output logic             legal
);

    int unsigned      ones;
    int unsigned      idx_full;
    logic [MAX_W-1:0] canon;

    // Count ones (MSB=0) or zeros (MSB=1); XOR with the MSB folds both cases.
    always_comb begin
        ones = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones = ones + 32'(code_in[i] ^ code_in[WIDTH-1]);
        end
        idx_full = code_in[WIDTH-1] ? (WIDTH + ones) : ones;
        index    = IW'(idx_full);
        canon    = johnson_code(idx_full, WIDTH);
        legal    = (canon[WIDTH-1:0] == code_in);
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson code receiver: decode, legality/sequence check, SEARCH/LOCKED tracking,
// saturating error count. All outputs registered, one cycle after the en sample.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter  int unsigned WIDTH      = 4,
    parameter  int unsigned LOCK_COUNT = 3,
    parameter  int unsigned ALLOW_HOLD = 0,
    localparam int unsigned IW         = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WIDTH-1:0]     code_in,
    output logic [IW-1:0]        index,
    output logic [2*WIDTH-1:0]   onehot,
    output logic                 valid,
    output logic                 locked,
    output logic                 err_code,
    output logic                 err_step,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [IW-1:0] dec_idx;
    logic          dec_legal;

    johnson_decode_comb #(
        .WIDTH (WIDTH)
    ) u_decode (
        .code_in (code_in),
        .index   (dec_idx),
        .legal   (dec_legal)
    );

    state_t                state_q, state_d;
    logic [3:0]            run_q, run_d;
    logic                  have_prev_q, have_prev_d;
    logic [IW-1:0]         index_q, index_d;
    logic [2*WIDTH-1:0]    onehot_q, onehot_d;
    logic                  valid_q, valid_d;
    logic                  err_code_q, err_code_d;
    logic                  err_step_q, err_step_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic [IW-1:0]         next_idx;
    logic                  err_inc;

    // index_q doubles as the previous-index register: it only moves on legal samples.
    assign next_idx = (index_q == IW'(2 * WIDTH - 1)) ? '0 : index_q + 1'b1;

    // Next-state: decode outcome drives tracking FSM, run counter and error pulses.
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        have_prev_d = have_prev_q;
        index_d     = index_q;
        onehot_d    = onehot_q;
        valid_d     = 1'b0;
        err_code_d  = 1'b0;
        err_step_d  = 1'b0;
        err_inc     = 1'b0;
        if (en) begin
            if (!dec_legal) begin
                err_code_d  = 1'b1;
                err_inc     = 1'b1;
                run_d       = '0;
                have_prev_d = 1'b0;
                state_d     = SEARCH;
            end else begin
                valid_d     = 1'b1;
                index_d     = dec_idx;
                onehot_d    = {{(2 * WIDTH - 1){1'b0}}, 1'b1} << dec_idx;
                have_prev_d = 1'b1;
                unique case (state_q)
                    SEARCH: begin
                        run_d = (have_prev_q && dec_idx == next_idx) ? run_q + 4'd1 : 4'd1;
                        if (run_d >= 4'(LOCK_COUNT)) state_d = LOCKED;
                    end
                    LOCKED: begin
                        if (!(dec_idx == next_idx ||
                              (ALLOW_HOLD != 0 && dec_idx == index_q))) begin
                            err_step_d = 1'b1;
                            err_inc    = 1'b1;
                            run_d      = 4'd1;
                            state_d    = SEARCH;
                        end
                    end
                    default: state_d = SEARCH;
                endcase
            end
        end
        err_count_d = err_count_q;
        if (err_inc && err_count_q != '1) err_count_d = err_count_q + 1'b1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            run_q       <= '0;
            have_prev_q <= 1'b0;
            index_q     <= '0;
            onehot_q    <= '0;
            valid_q     <= 1'b0;
            err_code_q  <= 1'b0;
            err_step_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            have_prev_q <= have_prev_d;
            index_q     <= index_d;
            onehot_q    <= onehot_d;
            valid_q     <= valid_d;
            err_code_q  <= err_code_d;
            err_step_q  <= err_step_d;
            err_count_q <= err_count_d;
        end
    end

    assign index     = index_q;
    assign onehot    = onehot_q;
    assign valid     = valid_q;
    assign locked    = (state_q == LOCKED);
    assign err_code  = err_code_q;
    assign err_step  = err_step_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder, WIDTH=4; two instances differ only in ALLOW_HOLD.
module tb_johnson_decoder;
    import johnson_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [3:0] code_in = 4'b0000;

    logic [2:0] idx0, idx1;
    logic [7:0] oh0, oh1;
    logic       v0, v1, lk0, lk1, ec0, ec1, es0, es1;
    logic [7:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    johnson_decoder #(.WIDTH(4), .LOCK_COUNT(3), .ALLOW_HOLD(0)) dut (
        .clk(clk), .reset(reset), .en(en), .code_in(code_in),
        .index(idx0), .onehot(oh0), .valid(v0), .locked(lk0),
        .err_code(ec0), .err_step(es0), .err_count(cnt0)
    );

    johnson_decoder #(.WIDTH(4), .LOCK_COUNT(3), .ALLOW_HOLD(1)) dut_h (
        .clk(clk), .reset(reset), .en(en), .code_in(code_in),
        .index(idx1), .onehot(oh1), .valid(v1), .locked(lk1),
        .err_code(ec1), .err_step(es1), .err_count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counter reference: canonical pattern for position i (mod 8).
    function automatic logic [3:0] jc(input int unsigned i);
        logic [31:0] t;
        t = johnson_code(i % 8, 4);
        return t[3:0];
    endfunction

    task automatic step(input logic e, input logic [3:0] c);
        @(negedge clk);
        reset   = 1'b0;
        en      = e;
        code_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        do_reset();
        do_reset();
        check("rst_index", 32'(idx0), 0);
        check("rst_onehot", 32'(oh0), 0);
        check("rst_valid", 32'(v0), 0);
        check("rst_locked", 32'(lk0), 0);
        check("rst_count", 32'(cnt0), 0);

        // Follow the counter through a wrap; lock after the third sample.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, jc(i));
            check("seq_valid", 32'(v0), 1);
            check("seq_index", 32'(idx0), 32'(i % 8));
            check("seq_onehot", 32'(oh0), 32'(1) << (i % 8));
            check("seq_locked", 32'(lk0), (i >= 2) ? 1 : 0);
            check("seq_errs", {30'd0, ec0, es0}, 0);
        end
        check("seq_count", 32'(cnt0), 0);

        // Illegal pattern while locked at index 3.
        step(1'b1, 4'b0101);
        check("bad_err_code", 32'(ec0), 1);
        check("bad_err_step", 32'(es0), 0);
        check("bad_valid", 32'(v0), 0);
        check("bad_locked", 32'(lk0), 0);
        check("bad_count", 32'(cnt0), 1);
        check("bad_index_hold", 32'(idx0), 3);
        step(1'b1, jc(4));
        check("relock4", 32'(lk0), 0);
        step(1'b1, jc(5));
        check("relock5", 32'(lk0), 0);
        step(1'b1, jc(6));
        check("relock6", 32'(lk0), 1);

        // Advance to index 2, then 3, then jump to 6.
        for (int i = 7; i < 11; i++) step(1'b1, jc(i));
        check("at2_locked", 32'(lk0), 1);
        check("at2_index", 32'(idx0), 2);
        step(1'b1, 4'b0111);
        check("step3_err", 32'(es0), 0);
        step(1'b1, 4'b1100);
        check("jump_err_step", 32'(es0), 1);
        check("jump_err_code", 32'(ec0), 0);
        check("jump_valid", 32'(v0), 1);
        check("jump_locked", 32'(lk0), 0);
        check("jump_index", 32'(idx0), 6);
        check("jump_count", 32'(cnt0), 2);
        check("jump_h_err_step", 32'(es1), 1);

        // Relock (run=1 at 6), reach index 4, then repeat 1111.
        step(1'b1, jc(7));
        check("rl7_locked", 32'(lk0), 0);
        step(1'b1, jc(0));
        check("rl0_locked", 32'(lk0), 1);
        for (int i = 1; i < 5; i++) step(1'b1, jc(i));
        check("at4_index", 32'(idx0), 4);
        check("at4_h_locked", 32'(lk1), 1);
        step(1'b1, 4'b1111);
        check("hold0_err_step", 32'(es0), 1);
        check("hold0_locked", 32'(lk0), 0);
        check("hold0_count", 32'(cnt0), 3);
        check("hold1_valid", 32'(v1), 1);
        check("hold1_err_step", 32'(es1), 0);
        check("hold1_locked", 32'(lk1), 1);
        check("hold1_count", 32'(cnt1), 2);

        // Error count saturation.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            step(1'b1, (k % 2 == 1) ? 4'b1011 : 4'b0101);
            if (k == 0) check("sat_first", 32'(cnt0), 1);
            if (k == 254) check("sat_255", 32'(cnt0), 255);
        end
        check("sat_hold", 32'(cnt0), 255);
        check("sat_hold_h", 32'(cnt1), 255);
        check("sat_err_code", 32'(ec0), 1);
        do_reset();
        check("sat_rst_count", 32'(cnt0), 0);
        check("sat_rst_locked", 32'(lk0), 0);
        check("sat_rst_onehot", 32'(oh0), 0);

        // Gapped sampling: en=0 cycles carry garbage and must be ignored.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, jc(k));
            check("gap_valid", 32'(v0), 1);
            check("gap_index", 32'(idx0), 32'(k));
            check("gap_locked", 32'(lk0), (k >= 2) ? 1 : 0);
            step(1'b0, 4'b0101);
            check("idle_valid", 32'(v0), 0);
            check("idle_err", {30'd0, ec0, es0}, 0);
            check("idle_index", 32'(idx0), 32'(k));
            check("idle_onehot", 32'(oh0), 32'(1) << k);
            check("idle_locked", 32'(lk0), (k >= 2) ? 1 : 0);
        end

        // Reset mid-lock with a legal sample present.
        @(negedge clk);
        reset   = 1'b1;
        en      = 1'b1;
        code_in = jc(4);
        @(posedge clk);
        #1;
        check("mid_rst_index", 32'(idx0), 0);
        check("mid_rst_onehot", 32'(oh0), 0);
        check("mid_rst_valid", 32'(v0), 0);
        check("mid_rst_locked", 32'(lk0), 0);
        check("mid_rst_errs", {30'd0, ec0, es0}, 0);
        check("mid_rst_count", 32'(cnt0), 0);
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
